wb_drain: RTL

Write-buffer drain engine: the reader side of the cache write-buffer FIFO with compare. It pops buffered stores ({address, byte strobes, data}) from the FIFO head and issues them one at a time on the valid/ready memory port. It drives the FIFO compare port to flag read-after-write hazards for the cache read path, and it provides flush and timeout handling. It sits between the write-buffer FIFO and the memory-port arbiter.

---
 rtl/wb_drain_if.sv | 40 ++++
 rtl/wb_drain.sv | 75 +++++++
 2 files changed

// File: rtl/wb_drain_if.sv
// wb_drain_if: FIFO head/compare, cache-read hazard, flush control and memory-port signals of the drain engine.
// master is the drain engine's view; slave is the surrounding FIFO/arbiter view.
interface wb_drain_if #(
    parameter int W_ADDR        = 32,
    parameter int W_DATA        = 32,
    parameter int C_NUMBERWORDS = 4
);
    logic                              FifoEmpty_i;
    logic [W_ADDR+W_DATA/8+W_DATA-1:0] FifoReadData_i;
    logic                              FifoRead_o;
    logic                              FifoCompareEn_o;
    logic [W_ADDR-3:0]                 FifoCompareData_o;
    logic [C_NUMBERWORDS-1:0]          FifoCompareResult_i;
    logic                              RdReq_i;
    logic [W_ADDR-1:0]                 RdAddr_i;
    logic                              RdHazard_oc;
    logic                              Pause_i;
    logic                              Flush_i;
    logic                              FlushDone_o;
    logic                              MemValid_o;
    logic [W_ADDR-1:0]                 MemAddr_o;
    logic [W_DATA-1:0]                 MemWData_o;
    logic [W_DATA/8-1:0]               MemWstrb_o;
    logic                              MemReady_i;
    logic                              Timeout_o;

    modport master (
        input  FifoEmpty_i, FifoReadData_i, FifoCompareResult_i, RdReq_i, RdAddr_i,
               Pause_i, Flush_i, MemReady_i,
        output FifoRead_o, FifoCompareEn_o, FifoCompareData_o, RdHazard_oc, FlushDone_o,
               MemValid_o, MemAddr_o, MemWData_o, MemWstrb_o, Timeout_o
    );

    modport slave (
        output FifoEmpty_i, FifoReadData_i, FifoCompareResult_i, RdReq_i, RdAddr_i,
               Pause_i, Flush_i, MemReady_i,
        input  FifoRead_o, FifoCompareEn_o, FifoCompareData_o, RdHazard_oc, FlushDone_o,
               MemValid_o, MemAddr_o, MemWData_o, MemWstrb_o, Timeout_o
    );
endinterface

// File: rtl/wb_drain.sv
// wb_drain: pops buffered stores from the write-buffer FIFO head and issues them on the memory port,
// flags read-after-write hazards and handles flush and timeout.
module wb_drain #(
    parameter int W_ADDR        = 32,
    parameter int W_DATA        = 32,
    parameter int C_NUMBERWORDS = 4,
    parameter int C_TIMEOUT     = 255
) (
    input logic        sClk_i,
    input logic        snRst_i,
    wb_drain_if.master bus
);
    localparam int W_STRB = W_DATA / 8;
    localparam int W_CNT  = $clog2(C_TIMEOUT + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [W_CNT-1:0]  r_cnt;
    logic              r_flush;
    logic              r_timeout;
    logic [W_ADDR-1:0] r_addr;
    logic [W_DATA-1:0] r_data;
    logic [W_STRB-1:0] r_strb;
    logic              w_launch;
    logic              w_expire;
    logic              w_done;
    logic              w_unused;

    always_comb begin
        w_launch = ~bus.FifoEmpty_i & (~bus.Pause_i | r_flush) & ((r_state == IDLE) | bus.MemReady_i);
        w_expire = (r_state == ISSUE) & ~bus.MemReady_i & (r_cnt == W_CNT'(C_TIMEOUT - 1));
        w_done   = r_flush & bus.FifoEmpty_i & (r_state == IDLE);
        w_next   = w_launch ? ISSUE :
                   ((r_state == ISSUE) & (bus.MemReady_i | w_expire)) ? IDLE : r_state;
    end

    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
            r_cnt     <= '0;
            r_flush   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_launch) {r_addr, r_strb, r_data} <= bus.FifoReadData_i;
            if (w_launch) r_cnt <= '0;
            else if ((r_state == ISSUE) && !bus.MemReady_i && (r_cnt != W_CNT'(C_TIMEOUT))) r_cnt <= r_cnt + W_CNT'(1);
            r_timeout <= r_timeout | w_expire;
            // a flush arriving in the completion cycle is absorbed into that completion
            r_flush   <= ~w_done & (r_flush | bus.Flush_i);
        end
    end

    // the popped entry lives only in the Mem* registers, so it is compared here as well as in the FIFO
    assign bus.RdHazard_oc       = bus.RdReq_i & (|bus.FifoCompareResult_i[C_NUMBERWORDS-1:0] |
                                   ((r_state == ISSUE) & (r_addr[W_ADDR-1:2] == bus.RdAddr_i[W_ADDR-1:2])));
    assign bus.FifoRead_o        = w_launch & snRst_i;
    assign bus.FifoCompareEn_o   = bus.RdReq_i;
    assign bus.FifoCompareData_o = bus.RdAddr_i[W_ADDR-1:2];
    assign bus.FlushDone_o       = w_done;
    assign bus.MemValid_o        = (r_state == ISSUE);
    assign bus.MemAddr_o         = r_addr;
    assign bus.MemWData_o        = r_data;
    assign bus.MemWstrb_o        = r_strb;
    assign bus.Timeout_o         = r_timeout;
    assign w_unused              = &{1'b0, bus.RdAddr_i[1:0]};
endmodule
